interp_filter_20: RTL and testbench
===================================

// Module: interp_filter_20
// PURPOSE
// - Transmit-path counterpart of the 20-tap decimate-by-5 RX low-pass: 20-tap polyphase interpolator, L=5.
// - Takes one low-rate signed sample, emits 5 filtered high-rate samples (phases 0..4).
// - Sits between the O-QPSK symbol/chip mapper (I or Q rail) and the DAC formatter; one instance per rail.
// PARAMETERS
// - DATA_W  5   input sample width, signed
// - OUT_W   8   output sample width, signed
// - SHIFT   6   arithmetic right shift applied to the phase sum before output sizing
// PORTS
// - clk        in   1       single clock, rising edge
// - reset      in   1       synchronous, active-high; sampled on rising edge of clk
// - in_valid   in   1       input sample offered
// - in_ready   out  1       block can accept a sample this cycle
// - data_in    in   DATA_W  signed input sample
// - out_valid  out  1       data_out holds a valid phase sample
// - out_ready  in   1       downstream accepts data_out this cycle
// - data_out   out  OUT_W   signed interpolated sample
// - phase      out  3       phase index 0..4 of data_out (debug/alignment)
// BEHAVIOUR
// - Coefficients h[0..19], 9-bit signed, symmetric h[k]=h[19-k]; h[0..9] = 1,-9,-2,13,14,-14,-39,-3,99,193.
// - Delay line x0..x3 (x0 newest), DATA_W each; shifts only on in_fire = in_valid & in_ready.
// - Phase p sum: S_p = h[p]*x0 + h[p+5]*x1 + h[p+10]*x2 + h[p+15]*x3; product 14b signed; S_p 16b signed, exact.
// - Output: Y = S_p >>> SHIFT (floor), then sized to OUT_W (see CONFIGURATION).
// - FSM: IDLE, RUN. Phase counter cnt 0..4, valid in RUN only.
//   - IDLE: in_ready=1, out_valid=0. in_fire -> RUN, cnt=0; next cycle data_out = phase 0 computed on updated line.
//   - RUN: out_valid=1; data_out/phase held stable while out_ready=0.
//   - out_fire (out_valid & out_ready) with cnt<4 -> cnt+1, data_out loads next phase.
//   - out_fire with cnt=4: in_fire in same cycle -> stay RUN, cnt=0, phase 0 of new sample next cycle (no bubble);
//     no in_fire -> IDLE.
// - in_ready = IDLE | (RUN & cnt==4 & out_ready); combinational from state and out_ready only; no input-side buffer.
// - Latency: in_fire at cycle N -> phase 0 on data_out, out_valid=1 at N+1. Full-rate throughput = 1 input per 5 clk.
// - Back-pressure: out_ready held low freezes cnt, data_out, delay line; in_ready stays 0.
// - Reset (any cycle, incl. mid-RUN): delay line=0, FSM=IDLE, cnt=0, data_out=0, phase=0, out_valid=0.
//   First cycle after reset deassert: in_ready=1.
// - in_valid with in_ready=0: sample ignored, upstream must hold it.
// CONFIGURATION
// - Macro INTERP_FILTER_SAT_EN.
//   - Defined: Y saturated to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]; output sticky_ovf (1 bit) added, set on any clip,
//     cleared by reset only.
//   - Undefined: Y truncated to low OUT_W bits (two's-complement wrap); no sticky_ovf port.
// TESTING
// - Reset: hold reset 3 clk mid-RUN (cnt=2) -> next cycle out_valid=0, data_out=0, in_ready=1, phase=0.
// - Impulse (SHIFT=0, OUT_W=16, out_ready=1): 15 then 0,0,0 -> 20 outputs 15*h[k]:
//   15,-135,-30,195,210,-210,-585,-45,1485,2895,2895,1485,...,15.
// - DC (defaults, SAT off/on): constant 15 -> steady phases 45,15,-3,15,45 (194,64,-10,64,194 *15 >>>6).
// - Saturation (SHIFT=0, OUT_W=8, DC 15, phase 0 sum 2910): SAT_EN -> 127 and sticky_ovf=1; else 94.
// - Back-pressure: out_ready low 7 clk at cnt=3 -> data_out/phase frozen, in_ready=0, no sample dropped
//   or duplicated; 5 outputs per input.
// - Back-to-back: in_valid held high, out_ready=1 -> in_fire every 5 clk, out_valid continuously 1,
//   phase 0,1,2,3,4,0,...

Source files
------------

// File: rtl/interp_filter_20.sv
// interp_filter_20: 20-tap polyphase interpolator, L=5; one low-rate sample in, five filtered phases out.
// Optional output saturation with sticky overflow flag is enabled by defining INTERP_FILTER_SAT_EN.
module interp_filter_20 #(
  parameter int DATA_W = 5,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic [2:0]        phase
`ifdef INTERP_FILTER_SAT_EN
  ,
  output logic              sticky_ovf
`endif
);

  localparam int COEF_W = 9;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int EXT_W  = ACC_W + OUT_W;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state, state_nx;
  logic [2:0]               cnt, cnt_nx;
  logic                     in_fire, out_fire, load;
  logic                     vld_p1;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] x0, x1, x2, x3;
  logic signed [DATA_W-1:0] l0_p0, l1_p0, l2_p0, l3_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic signed [EXT_W-1:0]  scl_p0;
  logic [OUT_W-1:0]         y_p0;

  // Symmetric prototype: only h[0..9] are stored, h[k] = h[19-k].
  function automatic logic signed [COEF_W-1:0] coef(input logic [4:0] k);
    logic [4:0] m;
    m = (k > 5'd9) ? (5'd19 - k) : k;
    case (m)
      5'd0:    coef = 9'sd1;
      5'd1:    coef = -9'sd9;
      5'd2:    coef = -9'sd2;
      5'd3:    coef = 9'sd13;
      5'd4:    coef = 9'sd14;
      5'd5:    coef = -9'sd14;
      5'd6:    coef = -9'sd39;
      5'd7:    coef = -9'sd3;
      5'd8:    coef = 9'sd99;
      default: coef = 9'sd193;
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] phase_sum(
    input logic [2:0]               p,
    input logic signed [DATA_W-1:0] a0,
    input logic signed [DATA_W-1:0] a1,
    input logic signed [DATA_W-1:0] a2,
    input logic signed [DATA_W-1:0] a3
  );
    logic [4:0] k;
    k = {2'b00, p};
    phase_sum = ACC_W'(coef(k))          * ACC_W'(a0)
              + ACC_W'(coef(k + 5'd5))  * ACC_W'(a1)
              + ACC_W'(coef(k + 5'd10)) * ACC_W'(a2)
              + ACC_W'(coef(k + 5'd15)) * ACC_W'(a3);
  endfunction

  function automatic logic signed [EXT_W-1:0] scale(input logic signed [ACC_W-1:0] s);
    scale = EXT_W'(s) >>> SHIFT;
  endfunction

`ifdef INTERP_FILTER_SAT_EN
  localparam logic signed [EXT_W-1:0] Y_MAX = {{(ACC_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] Y_MIN = {{(ACC_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic clip(input logic signed [EXT_W-1:0] v);
    clip = (v > Y_MAX) || (v < Y_MIN);
  endfunction

  function automatic logic [OUT_W-1:0] size_out(input logic signed [EXT_W-1:0] v);
    if (v > Y_MAX)      size_out = Y_MAX[OUT_W-1:0];
    else if (v < Y_MIN) size_out = Y_MIN[OUT_W-1:0];
    else                size_out = v[OUT_W-1:0];
  endfunction
`else
  function automatic logic [OUT_W-1:0] size_out(input logic signed [EXT_W-1:0] v);
    size_out = v[OUT_W-1:0];
  endfunction
`endif

  assign din       = signed'(data_in);
  assign vld_p1    = (state == RUN);
  assign out_valid = vld_p1;
  assign phase     = cnt;
  assign in_ready  = (state == IDLE) | (vld_p1 & (cnt == 3'd4) & out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = vld_p1 & out_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_nx = RUN;
          cnt_nx   = 3'd0;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (out_fire) begin
          if (cnt != 3'd4) begin
            cnt_nx = cnt + 3'd1;
            load   = 1'b1;
          end else if (in_fire) begin
            cnt_nx = 3'd0;
            load   = 1'b1;
          end else begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: phase sum on the line as it will stand after this edge
  always_comb begin
    if (in_fire) begin
      l0_p0 = din;
      l1_p0 = x0;
      l2_p0 = x1;
      l3_p0 = x2;
    end else begin
      l0_p0 = x0;
      l1_p0 = x1;
      l2_p0 = x2;
      l3_p0 = x3;
    end
  end

  assign sum_p0 = phase_sum(cnt_nx, l0_p0, l1_p0, l2_p0, l3_p0);
  assign scl_p0 = scale(sum_p0);
  assign y_p0   = size_out(scl_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Stage p1: delay line and held output sample
  always_ff @(posedge clk) begin
    if (reset) begin
      x0       <= '0;
      x1       <= '0;
      x2       <= '0;
      x3       <= '0;
      data_out <= '0;
    end else begin
      if (in_fire) begin
        x0 <= din;
        x1 <= x0;
        x2 <= x1;
        x3 <= x2;
      end
      if (load) data_out <= y_p0;
    end
  end

`ifdef INTERP_FILTER_SAT_EN
  always_ff @(posedge clk) begin
    if (reset)                      sticky_ovf <= 1'b0;
    else if (load && clip(scl_p0)) sticky_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_interp_filter_20.sv
// Bench for interp_filter_20: three sizings driven in lockstep and checked against a
// direct polyphase reference model (coefficient table, sample history, pending-output queue).
module tb_interp_filter_20;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              out_ready;
  logic [4:0]        data_in;
  logic              rdy_a, rdy_b, rdy_c;
  logic              ov_a, ov_b, ov_c;
  logic signed [7:0]  dout_a;
  logic signed [15:0] dout_b;
  logic signed [7:0]  dout_c;
  logic [2:0]        ph_a, ph_b, ph_c;
`ifdef INTERP_FILTER_SAT_EN
  logic              sticky_a, sticky_b, sticky_c;
`endif

  interp_filter_20 #(.DATA_W(5), .OUT_W(8), .SHIFT(6)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .data_in(data_in),
    .out_valid(ov_a), .out_ready(out_ready), .data_out(dout_a), .phase(ph_a)
`ifdef INTERP_FILTER_SAT_EN
    , .sticky_ovf(sticky_a)
`endif
  );

  interp_filter_20 #(.DATA_W(5), .OUT_W(16), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .data_in(data_in),
    .out_valid(ov_b), .out_ready(out_ready), .data_out(dout_b), .phase(ph_b)
`ifdef INTERP_FILTER_SAT_EN
    , .sticky_ovf(sticky_b)
`endif
  );

  interp_filter_20 #(.DATA_W(5), .OUT_W(8), .SHIFT(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c), .data_in(data_in),
    .out_valid(ov_c), .out_ready(out_ready), .data_out(dout_c), .phase(ph_c)
`ifdef INTERP_FILTER_SAT_EN
    , .sticky_ovf(sticky_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s;
    int ph;
  } ent_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   h[20];
  int   hist[4];
  ent_t q[$];
  int   cur_s;
  bit   fired_in;
  bit   after_rst;
  bit   rand_ready;
  bit   sticky_exp[3];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor shift then size to w bits (clamp when saturating, two's-complement wrap otherwise).
  function automatic int sized(input int s, input int sh, input int w, output bit clipped);
    int v, hi, lo, m;
    v  = s >>> sh;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    clipped = (v > hi) || (v < lo);
`ifdef INTERP_FILTER_SAT_EN
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
`else
    m = v & ((1 << w) - 1);
    if (m > hi) m = m - (1 << w);
    v = m;
`endif
    return v;
  endfunction

  task automatic step();
    bit   er;
    bit   c0, c1, c2;
    int   s;
    ent_t e;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    er = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("in_ready_a", rdy_a, er);
    chk("in_ready_b", rdy_b, er);
    chk("in_ready_c", rdy_c, er);
    chk("out_valid_a", ov_a, q.size() != 0);
    chk("out_valid_b", ov_b, q.size() != 0);
    chk("out_valid_c", ov_c, q.size() != 0);
    if (q.size() != 0) begin
      chk("phase_a", ph_a, q[0].ph);
      chk("phase_b", ph_b, q[0].ph);
      chk("phase_c", ph_c, q[0].ph);
      chk("data_a_sh6_w8", dout_a, sized(q[0].s, 6, 8, c0));
      chk("data_b_sh0_w16", dout_b, sized(q[0].s, 0, 16, c1));
      chk("data_c_sh0_w8", dout_c, sized(q[0].s, 0, 8, c2));
    end else if (after_rst) begin
      chk("rst_data_a", dout_a, 0);
      chk("rst_data_b", dout_b, 0);
      chk("rst_data_c", dout_c, 0);
      chk("rst_phase_a", ph_a, 0);
    end
`ifdef INTERP_FILTER_SAT_EN
    chk("sticky_a", sticky_a, sticky_exp[0]);
    chk("sticky_b", sticky_b, sticky_exp[1]);
    chk("sticky_c", sticky_c, sticky_exp[2]);
`endif
    fired_in = 1'b0;
    if (reset) begin
      q.delete();
      hist = '{default: 0};
      sticky_exp = '{default: 1'b0};
      after_rst = 1'b1;
    end else begin
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && er) begin
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = cur_s;
        for (int p = 0; p < 5; p++) begin
          s = 0;
          for (int j = 0; j < 4; j++) s += h[p + 5 * j] * hist[j];
          e.s  = s;
          e.ph = p;
          q.push_back(e);
        end
        fired_in  = 1'b1;
        after_rst = 1'b0;
      end
      if (q.size() != 0) begin
        void'(sized(q[0].s, 6, 8, c0));
        void'(sized(q[0].s, 0, 16, c1));
        void'(sized(q[0].s, 0, 8, c2));
        sticky_exp[0] |= c0;
        sticky_exp[1] |= c1;
        sticky_exp[2] |= c2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    int g;
    g = 0;
    cur_s    = s;
    data_in  = s[4:0];
    in_valid = 1'b1;
    do begin
      step();
      g++;
    end while (!fired_in && g < 100);
    in_valid = 1'b0;
    assert (fired_in) else begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout: observed no accept, expected accept of %0d", s);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      step();
      g++;
    end
    assert (q.size() == 0) else begin
      vectors++;
      miscompares++;
      $error("FAIL drain_timeout: observed %0d pending, expected 0", q.size());
    end
  endtask

  task automatic wait_phase(input int p);
    int g;
    g = 0;
    while (q.size() != 0 && q[0].ph != p && g < 50) begin
      step();
      g++;
    end
    assert (q.size() != 0 && q[0].ph == p) else begin
      vectors++;
      miscompares++;
      $error("FAIL wait_phase: observed no phase %0d, expected phase %0d", p, p);
    end
  endtask

  initial begin
    int half[10];
    half = '{1, -9, -2, 13, 14, -14, -39, -3, 99, 193};
    for (int k = 0; k < 10; k++) begin
      h[k]      = half[k];
      h[19 - k] = half[k];
    end
    hist       = '{default: 0};
    sticky_exp = '{default: 1'b0};
    after_rst  = 1'b1;
    rand_ready = 1'b0;
    cur_s      = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Impulse: 20 outputs equal 15*h[k] on the unshifted 16-bit instance
    send(15); send(0); send(0); send(0);
    drain();

    // DC 15 back-to-back; steady phases 45,15,-3,15,45 and wrap/saturation of 2910
    repeat (8) send(15);
    drain();

    // Back-pressure at phase 3 for 7 cycles
    send(7);
    wait_phase(3);
    out_ready = 1'b0;
    repeat (7) step();
    out_ready = 1'b1;
    drain();

    // Stalled at phase 4 with a sample waiting: it must not be taken
    send(-5);
    wait_phase(4);
    out_ready = 1'b0;
    cur_s     = -16;
    data_in   = 5'b10000;
    in_valid  = 1'b1;
    repeat (3) step();
    out_ready = 1'b1;
    send(-16);
    drain();

    // Full-scale extremes
    send(-16); send(-16); send(15); send(-16); send(15); send(-16);
    drain();

    // Random samples with random gaps and random out_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(int'($urandom_range(0, 31)) - 16);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    // Reset held 3 cycles mid-RUN at phase 2
    send(9);
    wait_phase(2);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    send(11);
    send(-3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
